roundtrip_report_packetizer: RTL and testbench
==============================================

// Module: roundtrip_report_packetizer
// PURPOSE
//  Downstream stage of the roundtrip-time monitor. Consumes each averaged roundtrip time over a
//  valid/ready handshake and packs it into a 2-flit NoC message (head + tail). It pushes the
//  flits into the tile's local APB send FIFO so the value reaches the CSR tile. Sole path by
//  which the monitor's averages leave the tile.
// PARAMETERS
//  DATA_WIDTH     16   width of average_data_i; <=32 (<=24 when ROUNDTRIP_PKT_SEQNUM_EN)
//  FLIT_WIDTH     34   NoC flit width: 2-bit preamble + 32-bit body
//  THIS_TILE_ID   0    8-bit source tile id placed in header
//  CSR_TILE_ID    0    8-bit destination tile id placed in header
//  CSR_REG_IDX    0    8-bit CSR register index placed in header
// PORTS
//  clk_i                  in   1           clock
//  rstn_i                 in   1           async reset, active-low
//  average_data_i         in   DATA_WIDTH  averaged roundtrip time
//  average_valid_i        in   1           average_data_i valid
//  average_ready_o        out  1           packetizer accepts a sample this cycle
//  local_apb_snd_data_o   out  FLIT_WIDTH  flit to send FIFO
//  local_apb_snd_wrreq_o  out  1           FIFO write strobe
//  local_apb_snd_full_i   in   1           FIFO full; no write may be issued while high
// BEHAVIOUR
//  Reset and clock: one clock domain (clk_i); rstn_i async assert, sync deassert upstream.
//   Reset: state IDLE, sample reg 0, wrreq_o 0, data_o 0, seq 0.
//  FSM states: IDLE, HEAD, TAIL.
//   IDLE: ready_o=1. On valid_i, capture data_i and go to HEAD.
//   HEAD: wrreq_o=!full_i and data_o=header flit. If !full_i, go to TAIL; else stay.
//   TAIL: wrreq_o=!full_i and data_o=payload flit. ready_o=!full_i.
//    If !full_i and valid_i: capture the new sample and go to HEAD (back-to-back).
//    If !full_i and !valid_i: go to IDLE. If full_i: stay.
//  Handshake: a sample transfers when valid_i && ready_o. ready_o depends only on state and full_i,
//   never on valid_i. wrreq_o is never high while full_i is high.
//  Outputs: wrreq_o and data_o are combinational from state, full_i, and the sample register.
//   data_o=0 whenever wrreq_o=0.
//  Latency: sample accepted in cycle N gives head write in N+1 and tail write in N+2 (FIFO not full).
//   Sustained throughput is 1 sample per 2 cycles.
//  Header flit: [33:32]=2'b10, [31:24]=THIS_TILE_ID, [23:16]=CSR_TILE_ID, [15:11]=MSG_MON_REPORT,
//   [10:8]=0, [7:0]=CSR_REG_IDX.
//  Payload flit: [33:32]=2'b01, [31:0]=data zero-extended from DATA_WIDTH.
//  Back-pressure: full_i may stall in HEAD or TAIL for any number of cycles. Flit content stays
//   stable while stalled, and no flit is dropped or duplicated.
//  Reset mid-packet: the FSM aborts to IDLE and the captured sample is lost. The send FIFO shares
//   rstn_i, so no orphan head flit survives.
// CONFIGURATION
//  ROUNDTRIP_PKT_SEQNUM_EN defined:
//   8-bit seq counter; payload [31:24]=seq, [23:0]=data zero-extended.
//   seq increments on each tail write and wraps 255->0.
//   Elaboration error if DATA_WIDTH>24.
//  ROUNDTRIP_PKT_SEQNUM_EN undefined: no counter; payload as described above.
// STRUCTURE
//  Package roundtrip_mon_pkg contents:
//   PREAMBLE_HEAD/PREAMBLE_TAIL constants and MSG_MON_REPORT (5'b10010).
//   typedef enum pkt_state_t {IDLE,HEAD,TAIL} and typedef struct packed mon_hdr_t.
//   function make_header() and function make_payload().
//  No sub-module. The FSM, sample register and seq counter live in this module.
// TESTING
//  - Reset then single sample: data_i=16'h01F4, full_i=0 -> ready high in IDLE; head flit one cycle
//    later (34'h2_0000_9000 with CSR_TILE_ID=0 etc.); then tail 34'h1_0000_01F4.
//  - Back-to-back: valid_i held high with 4 samples 1,2,3,4 -> 8 writes in 8 consecutive cycles,
//    alternating head/tail, payloads 1,2,3,4.
//  - Stall: full_i=1 for 5 cycles during HEAD, then again for 3 cycles during TAIL -> wrreq_o=0
//    while full; each flit written exactly once; ready_o=0 throughout.
//  - Mid-packet reset: drop rstn_i in TAIL -> wrreq_o=0 immediately. After release, next sample
//    0x0007 produces a clean head+tail.
//  - SEQNUM_EN: send 257 samples -> payload seq runs 0..255,0 and data field matches each sample.
//  - Random valid_i/full_i for 10k cycles -> scoreboard: in-order, lossless, no write while full.

Source files
------------

// File: rtl/roundtrip_mon_pkg.sv
// Shared types, flit constants and flit builders for the roundtrip-time monitor.
package roundtrip_mon_pkg;

  localparam logic [1:0] PREAMBLE_HEAD  = 2'b10;
  localparam logic [1:0] PREAMBLE_TAIL  = 2'b01;
  localparam logic [4:0] MSG_MON_REPORT = 5'b10010;

  typedef enum logic [1:0] {
    IDLE,
    HEAD,
    TAIL
  } pkt_state_t;

  typedef struct packed {
    logic [1:0] preamble;
    logic [7:0] src_tile;
    logic [7:0] dst_tile;
    logic [4:0] msg_type;
    logic [2:0] reserved;
    logic [7:0] reg_idx;
  } mon_hdr_t;

  function automatic logic [33:0] make_header(input logic [7:0] src_tile,
                                              input logic [7:0] dst_tile,
                                              input logic [7:0] reg_idx);
    mon_hdr_t hdr;
    hdr.preamble = PREAMBLE_HEAD;
    hdr.src_tile = src_tile;
    hdr.dst_tile = dst_tile;
    hdr.msg_type = MSG_MON_REPORT;
    hdr.reserved = '0;
    hdr.reg_idx  = reg_idx;
    return hdr;
  endfunction

  function automatic logic [33:0] make_payload(input logic [31:0] body);
    return {PREAMBLE_TAIL, body};
  endfunction

endpackage

// File: rtl/roundtrip_report_packetizer.sv
// Packs each averaged roundtrip time into a head+tail NoC message for the local APB send FIFO.
// Define ROUNDTRIP_PKT_SEQNUM_EN to carry an 8-bit sequence number in payload bits [31:24].
module roundtrip_report_packetizer
  import roundtrip_mon_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned FLIT_WIDTH   = 34,
  parameter logic [7:0]  THIS_TILE_ID = 8'd0,
  parameter logic [7:0]  CSR_TILE_ID  = 8'd0,
  parameter logic [7:0]  CSR_REG_IDX  = 8'd0
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [DATA_WIDTH-1:0] average_data_i,
  input  logic                  average_valid_i,
  output logic                  average_ready_o,
  output logic [FLIT_WIDTH-1:0] local_apb_snd_data_o,
  output logic                  local_apb_snd_wrreq_o,
  input  logic                  local_apb_snd_full_i
);

`ifdef ROUNDTRIP_PKT_SEQNUM_EN
  localparam int unsigned BODY_W = 24;
`else
  localparam int unsigned BODY_W = 32;
`endif

  if (DATA_WIDTH > BODY_W) begin : g_width_check
    $error("DATA_WIDTH exceeds the payload data field");
  end

  localparam logic [33:0] HDR_FLIT = make_header(THIS_TILE_ID, CSR_TILE_ID, CSR_REG_IDX);

  pkt_state_t            state;
  logic [DATA_WIDTH-1:0] sample;
  logic [BODY_W-1:0]     data_ext;
  logic [33:0]           flit;
  logic                  tail_wr;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state  <= IDLE;
      sample <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (average_valid_i) begin
            sample <= average_data_i;
            state  <= HEAD;
          end
        end
        HEAD: begin
          if (!local_apb_snd_full_i) state <= TAIL;
        end
        TAIL: begin
          // The tail write cycle also accepts the next sample, giving 1 sample per 2 cycles.
          if (!local_apb_snd_full_i) begin
            if (average_valid_i) begin
              sample <= average_data_i;
              state  <= HEAD;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tail_wr = (state == TAIL) && !local_apb_snd_full_i;

`ifdef ROUNDTRIP_PKT_SEQNUM_EN
  logic [7:0] seq;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      seq <= '0;
    end else if (tail_wr) begin
      seq <= seq + 8'd1;
    end
  end
`endif

  always_comb begin
    data_ext                 = '0;
    data_ext[DATA_WIDTH-1:0] = sample;
  end

  always_comb begin
    flit                  = '0;
    local_apb_snd_wrreq_o = 1'b0;
    average_ready_o       = 1'b0;
    case (state)
      IDLE: average_ready_o = 1'b1;
      HEAD: begin
        local_apb_snd_wrreq_o = !local_apb_snd_full_i;
        if (!local_apb_snd_full_i) flit = HDR_FLIT;
      end
      TAIL: begin
        local_apb_snd_wrreq_o = tail_wr;
        average_ready_o       = tail_wr;
`ifdef ROUNDTRIP_PKT_SEQNUM_EN
        if (tail_wr) flit = make_payload({seq, data_ext});
`else
        if (tail_wr) flit = make_payload(data_ext);
`endif
      end
      default: ;
    endcase
  end

  assign local_apb_snd_data_o = FLIT_WIDTH'(flit);

endmodule

// File: tb/tb_roundtrip_report_packetizer.sv
// Scoreboard bench for roundtrip_report_packetizer: accepted samples queue their expected flits,
// every FIFO write pops and compares one.
module tb_roundtrip_report_packetizer;

  localparam int unsigned DW     = 16;
  localparam logic [7:0]  SRC_ID = 8'h12;
  localparam logic [7:0]  DST_ID = 8'h34;
  localparam logic [7:0]  REG_ID = 8'h56;
  localparam logic [33:0] EXP_HDR = {2'b10, SRC_ID, DST_ID, 5'b10010, 3'b000, REG_ID};

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [DW-1:0] data = '0;
  logic          valid = 1'b0;
  logic          ready;
  logic [33:0]   flit;
  logic          wrreq;
  logic          full = 1'b0;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [33:0] exp_q[$];
  logic [7:0]  exp_seq = '0;

  roundtrip_report_packetizer #(
    .DATA_WIDTH  (DW),
    .FLIT_WIDTH  (34),
    .THIS_TILE_ID(SRC_ID),
    .CSR_TILE_ID (DST_ID),
    .CSR_REG_IDX (REG_ID)
  ) dut (
    .clk_i                (clk),
    .rstn_i               (rstn),
    .average_data_i       (data),
    .average_valid_i      (valid),
    .average_ready_o      (ready),
    .local_apb_snd_data_o (flit),
    .local_apb_snd_wrreq_o(wrreq),
    .local_apb_snd_full_i (full)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] exp_payload(input logic [DW-1:0] d, input logic [7:0] s);
`ifdef ROUNDTRIP_PKT_SEQNUM_EN
    return {2'b01, s, 8'h00, d};
`else
    return {2'b01, 16'h0000, d} | {26'd0, s & 8'h00};
`endif
  endfunction

  // Scoreboard monitor: compare writes first, then queue flits for this cycle's handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        exp_q.delete();
        exp_seq = '0;
      end else begin
        check_val("wr_while_full", 34'(wrreq && full), 34'd0);
        if (wrreq) begin
          if (exp_q.size() == 0) check_val("unexpected_write", 34'd1, 34'd0);
          else check_val("flit", flit, exp_q.pop_front());
        end else if (flit !== '0) begin
          check_val("idle_data", flit, 34'd0);
        end
        if (valid && ready) begin
          exp_q.push_back(EXP_HDR);
          exp_q.push_back(exp_payload(data, exp_seq));
          exp_seq = exp_seq + 8'd1;
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] d);
    valid = 1'b1;
    data  = d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ready) begin
        @(posedge clk);
        #1 valid = 1'b0;
        return;
      end
    end
    check_val("send_timeout", 34'd1, 34'd0);
    valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    valid = 1'b0;
    full  = 1'b0;
    repeat (6) @(posedge clk);
    #1 check_val(tag, 34'(exp_q.size()), 34'd0);
  endtask

  initial begin
    int wr_cnt;
    int first_wr;
    int last_wr;
    int k;

    // Reset state
    #12;
    check_val("rst_wrreq", 34'(wrreq), 34'd0);
    check_val("rst_data", flit, 34'd0);
    check_val("rst_ready", 34'(ready), 34'd1);
    @(posedge clk);
    #1 rstn = 1'b1;

    // Single sample with latency
    @(negedge clk);
    check_val("idle_ready", 34'(ready), 34'd1);
    @(posedge clk);
    #1 send(16'h01F4);
    @(negedge clk);
    check_val("single_head_wr", 34'(wrreq), 34'd1);
    check_val("single_head", flit, EXP_HDR);
    @(negedge clk);
    check_val("single_tail_wr", 34'(wrreq), 34'd1);
    check_val("single_tail", flit, 34'h1_0000_01F4);
    drain("single_drain");

    // Back-to-back: 4 samples, 8 consecutive writes
    wr_cnt = 0; first_wr = -1; last_wr = -1; k = 1;
    valid = 1'b1;
    data  = DW'(1);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (wrreq) begin
        wr_cnt++;
        if (first_wr < 0) first_wr = c;
        last_wr = c;
      end
      if (valid && ready) k++;
      @(posedge clk);
      #1;
      if (k > 4) valid = 1'b0;
      else data = DW'(k);
    end
    check_val("b2b_writes", 34'(wr_cnt), 34'd8);
    check_val("b2b_span", 34'(last_wr - first_wr), 34'd7);
    drain("b2b_drain");

    // Stall in HEAD for 5 cycles, then in TAIL for 3 cycles
    send(16'hBEEF);
    full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_val("stall_head_wr", 34'(wrreq), 34'd0);
      check_val("stall_head_rdy", 34'(ready), 34'd0);
    end
    @(posedge clk);
    #1 full = 1'b0;
    @(negedge clk);
    check_val("stall_head_flit", flit, EXP_HDR);
    @(posedge clk);
    #1 full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_val("stall_tail_wr", 34'(wrreq), 34'd0);
      check_val("stall_tail_rdy", 34'(ready), 34'd0);
    end
    @(posedge clk);
    #1 full = 1'b0;
    @(negedge clk);
    check_val("stall_tail_wr_go", 34'(wrreq), 34'd1);
    drain("stall_drain");

    // Mid-packet reset in TAIL
    send(16'h0009);
    @(posedge clk);
    #1 rstn = 1'b0;
    #1 check_val("midrst_wrreq", 34'(wrreq), 34'd0);
    check_val("midrst_data", flit, 34'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    send(16'h0007);
    @(negedge clk);
    check_val("postrst_head", flit, EXP_HDR);
    @(negedge clk);
    check_val("postrst_tail", flit, 34'h1_0000_0007);
    drain("postrst_drain");

`ifdef ROUNDTRIP_PKT_SEQNUM_EN
    // Sequence number wrap over 257 samples
    @(posedge clk);
    #1 rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    k = 0;
    valid = 1'b1;
    data  = DW'($urandom);
    for (int c = 0; c < 800 && k < 257; c++) begin
      @(negedge clk);
      if (valid && ready) k++;
      @(posedge clk);
      #1;
      if (k >= 257) valid = 1'b0;
      else data = DW'($urandom);
    end
    check_val("seq_samples", 34'(k), 34'd257);
    drain("seq_drain");
`endif

    // Random valid/full traffic
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk);
      #1;
      if (!(valid && !ready)) data = DW'($urandom);
      valid = ($urandom_range(0, 99) < 60);
      full  = ($urandom_range(0, 99) < 30);
    end
    drain("rand_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
